// File: rtl/alu_md.sv
// Integer ALU with iterative RISC-V M-extension multiply/divide.
// Base ops finish in one cycle; MUL/DIV retire one bit per cycle.
module alu_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic            imm_en,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            flag_n,
    output logic            flag_z,
    output logic            flag_c,
    output logic            busy
);

    localparam int LG = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [LG-1:0]   CNT_LAST = LG'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [LG-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [1:0]      sub_q, sub_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            fn_q, fn_d;
    logic            fz_q, fz_d;
    logic            fc_q, fc_d;

    logic            accept;
    logic [XLEN-1:0] op2, add_rhs;
    logic [XLEN:0]   add_sum;
    logic            is_sub;
    logic [LG-1:0]   shamt;
    logic            is_m, is_mul, is_div, is_rem;
    logic            a_neg, b_neg, div_zero, div_ovf, go_iter;
    logic            mul_sa, mul_sb, div_s;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN-1:0] fast_res;
    logic            fast_c;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic [XLEN+1:0]   div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   acc_n, lo_n;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, iter_res;

    logic            ld_res, new_c;
    logic [XLEN-1:0] new_res;

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign result    = res_q;
    assign flag_n    = fn_q;
    assign flag_z    = fz_q;
    assign flag_c    = fc_q;

    // SUB with an immediate operand degrades to ADD
    assign op2     = imm_en ? imm : b;
    assign is_sub  = (op == 5'd1) && !imm_en;
    assign add_rhs = is_sub ? ~op2 : op2;
    assign add_sum = {1'b0, a} + {1'b0, add_rhs} + {{XLEN{1'b0}}, is_sub};
    assign shamt   = op2[LG-1:0];

    assign is_m     = op[4] & ~op[3];
    assign is_mul   = is_m & ~op[2];
    assign is_div   = is_m & op[2];
    assign is_rem   = op[1];
    assign div_s    = ~op[0];
    assign mul_sa   = op[0] ^ op[1];
    assign mul_sb   = op[0] & ~op[1];
    assign a_neg    = a[XLEN-1];
    assign b_neg    = b[XLEN-1];
    assign a_abs    = a_neg ? -a : a;
    assign b_abs    = b_neg ? -b : b;
    assign div_zero = (b == '0);
    assign div_ovf  = div_s && (a == MIN_NEG) && (b == '1);
    assign go_iter  = is_mul | (is_div & ~div_zero & ~div_ovf);

    always_comb begin
        fast_res = '0;
        fast_c   = 1'b0;
        case (op)
            5'd0, 5'd1: begin
                fast_res = add_sum[XLEN-1:0];
                fast_c   = add_sum[XLEN];
            end
            5'd2: fast_res = a << shamt;
            5'd3: fast_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(op2)};
            5'd4: fast_res = {{(XLEN-1){1'b0}}, a < op2};
            5'd5: fast_res = a ^ op2;
            5'd6: fast_res = a >> shamt;
            5'd7: fast_res = $signed(a) >>> shamt;
            5'd8: fast_res = a | op2;
            5'd9: fast_res = a & op2;
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (div_zero) fast_res = is_rem ? a : '1;
                else          fast_res = is_rem ? '0 : a;
            end
            default: fast_res = '0;
        endcase
    end

    // Shift-add multiply and restoring divide share acc/lo
    assign mul_sum  = {1'b0, acc_q} + {1'b0, lo_q[0] ? opnd_q : '0};
    assign div_sh   = {acc_q, lo_q[XLEN-1]};
    assign div_diff = {1'b0, div_sh} - {2'b0, opnd_q};
    assign div_ge   = ~(div_diff[XLEN+1] | div_diff[XLEN]);

    always_comb begin
        if (state_q == S_MUL) begin
            acc_n = mul_sum[XLEN:1];
            lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            acc_n = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            lo_n  = {lo_q[XLEN-2:0], div_ge};
        end
    end

    assign prod   = {acc_n, lo_n};
    assign prod_s = negq_q ? -prod : prod;
    assign quo_s  = negq_q ? -lo_n : lo_n;
    assign rem_s  = negr_q ? -acc_n : acc_n;

    always_comb begin
        if (state_q == S_MUL)
            iter_res = (sub_q == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else
            iter_res = sub_q[1] ? rem_s : quo_s;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        sub_d   = sub_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        res_d   = res_q;
        fn_d    = fn_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
        ld_res  = 1'b0;
        new_res = '0;
        new_c   = 1'b0;
        case (state_q)
            S_MUL, S_DIV: begin
                acc_d = acc_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + LG'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    ld_res  = 1'b1;
                    new_res = iter_res;
                end
            end
            default: begin
                if (accept) begin
                    if (go_iter) begin
                        state_d = is_mul ? S_MUL : S_DIV;
                        cnt_d   = '0;
                        acc_d   = '0;
                        sub_d   = op[1:0];
                        if (is_mul) begin
                            lo_d   = mul_sb ? b_abs : b;
                            opnd_d = mul_sa ? a_abs : a;
                            negq_d = (mul_sa & a_neg) ^ (mul_sb & b_neg);
                            negr_d = 1'b0;
                        end else begin
                            lo_d   = div_s ? a_abs : a;
                            opnd_d = div_s ? b_abs : b;
                            negq_d = div_s & (a_neg ^ b_neg);
                            negr_d = div_s & a_neg;
                        end
                    end else begin
                        state_d = S_DONE;
                        ld_res  = 1'b1;
                        new_res = fast_res;
                        new_c   = fast_c;
                    end
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        if (ld_res) begin
            res_d = new_res;
            fn_d  = new_res[XLEN-1];
            fz_d  = (new_res == '0);
            fc_d  = new_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            sub_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            res_q   <= '0;
            fn_q    <= 1'b0;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            sub_q   <= sub_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            res_q   <= res_d;
            fn_q    <= fn_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Directed plus randomized bench for alu_md at XLEN=32,
// checked against an arithmetic reference model.
module tb_alu_md;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic        imm_en;
    logic [31:0] a, b, imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_n, flag_z, flag_c, busy;

    int checks   = 0;
    int failures = 0;

    alu_md #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .imm_en   (imm_en),
        .a        (a),
        .b        (b),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {carry, result}
    function automatic logic [32:0] model(input logic [4:0] o, input logic ie,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] im);
        logic [31:0] p2;
        logic [31:0] r;
        logic        c;
        logic [63:0] up;
        logic signed [63:0] sp;
        p2 = ie ? im : y;
        r  = 32'h0;
        c  = 1'b0;
        case (o)
            5'd0: {c, r} = {1'b0, x} + {1'b0, p2};
            5'd1: begin
                if (ie) {c, r} = {1'b0, x} + {1'b0, p2};
                else begin
                    r = x - p2;
                    c = (x >= p2);
                end
            end
            5'd2: r = x << p2[4:0];
            5'd3: r = ($signed(x) < $signed(p2)) ? 32'd1 : 32'd0;
            5'd4: r = (x < p2) ? 32'd1 : 32'd0;
            5'd5: r = x ^ p2;
            5'd6: r = x >> p2[4:0];
            5'd7: r = $signed(x) >>> p2[4:0];
            5'd8: r = x | p2;
            5'd9: r = x & p2;
            5'd16: begin
                up = {32'h0, x} * {32'h0, y};
                r  = up[31:0];
            end
            5'd17: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                r  = sp[63:32];
            end
            5'd18: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({32'h0, y});
                r  = sp[63:32];
            end
            5'd19: begin
                up = {32'h0, x} * {32'h0, y};
                r  = up[63:32];
            end
            5'd20: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else r = $signed(x) / $signed(y);
            end
            5'd21: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'd22: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
                else r = $signed(x) % $signed(y);
            end
            5'd23: r = (y == 0) ? x : x % y;
            default: r = 32'h0;
        endcase
        return {c, r};
    endfunction

    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o >= 5'd16 && o <= 5'd19) return 33;
        if (o >= 5'd20 && o <= 5'd23) begin
            if (y == 0) return 1;
            if ((o == 5'd20 || o == 5'd22) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    function automatic logic [31:0] rv();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 9);
            default: return $urandom;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is seen
    task automatic run_op(input logic [4:0] o, input logic ie, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] im);
        logic [32:0] e;
        int el, lat, bcnt;
        string t;
        e  = model(o, ie, x, y, im);
        el = exp_lat(o, x, y);
        t  = $sformatf("op%0d a=%0h b=%0h", o, x, y);
        op = o; imm_en = ie; a = x; b = y; imm = im;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({t, " in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 5'($urandom); a = $urandom; b = $urandom; imm = $urandom;
        imm_en = 1'($urandom);
        lat  = 0;
        bcnt = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            bcnt += int'(busy);
        end
        chk({t, " latency"}, 64'(lat), 64'(el));
        chk({t, " busy_cycles"}, 64'(bcnt), 64'((el == 33) ? 32 : 0));
        chk({t, " result"}, 64'(result), 64'(e[31:0]));
        chk({t, " flag_c"}, 64'(flag_c), 64'(e[32]));
        chk({t, " flag_n"}, 64'(flag_n), 64'(e[31]));
        chk({t, " flag_z"}, 64'(flag_z), 64'(e[31:0] == 32'h0));
    endtask

    initial begin
        logic [32:0] e;
        logic [4:0]  o;
        int          seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 5'd0; imm_en = 1'b0; a = 32'h0; b = 32'h0; imm = 32'h0;
        #2;
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset result", 64'(result), 64'(0));
        chk("reset flags", 64'({flag_n, flag_z, flag_c}), 64'(0));
        chk("reset busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(5'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        run_op(5'd7, 1'b0, 32'h8000_0000, 32'd31, 32'h0);
        run_op(5'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        run_op(5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0);
        run_op(5'd17, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0);
        run_op(5'd20, 1'b0, -32'sd7, 32'd2, 32'h0);
        run_op(5'd22, 1'b0, -32'sd7, 32'd2, 32'h0);
        run_op(5'd21, 1'b0, 32'h1234_5678, 32'h0, 32'h0);
        run_op(5'd20, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        run_op(5'd1, 1'b1, 32'd10, 32'd3, 32'd5);
        run_op(5'd1, 1'b0, 32'd3, 32'd10, 32'd5);
        run_op(5'd2, 1'b0, 32'hA5A5_A5A5, 32'd0, 32'h0);
        run_op(5'd18, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7);
        run_op(5'd12, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom % 2 == 0) o = 5'(16 + $urandom % 8);
            else o = 5'($urandom % 32);
            run_op(o, 1'($urandom), rv(), rv(), rv());
        end

        // Backpressure: result must hold while the consumer stalls
        run_op(5'd0, 1'b0, 32'd100, 32'd23, 32'h0);
        out_ready = 1'b0;
        e = model(5'd1, 1'b0, 32'd50, 32'd70, 32'h0);
        op = 5'd1; imm_en = 1'b0; a = 32'd50; b = 32'd70; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall out_valid", 64'(out_valid), 64'(1));
            chk("stall result", 64'(result), 64'(123));
            chk("stall flags", 64'({flag_n, flag_z, flag_c}), 64'(0));
            chk("stall in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("after stall out_valid", 64'(out_valid), 64'(1));
        chk("after stall result", 64'(result), 64'(e[31:0]));
        chk("after stall flag_c", 64'(flag_c), 64'(e[32]));
        chk("after stall flag_n", 64'(flag_n), 64'(e[31]));

        // Back-to-back single-cycle ops
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            o = 5'($urandom % 10);
            imm_en = 1'($urandom); a = rv(); b = rv(); imm = rv(); op = o;
            e = model(o, imm_en, a, b, imm);
            #1;
            chk("b2b in_ready", 64'(in_ready), 64'(1));
            @(negedge clk);
            chk($sformatf("b2b op%0d out_valid", o), 64'(out_valid), 64'(1));
            chk($sformatf("b2b op%0d result", o), 64'(result), 64'(e[31:0]));
            chk($sformatf("b2b op%0d flag_c", o), 64'(flag_c), 64'(e[32]));
        end
        in_valid = 1'b0;

        // Reset in the middle of a DIVU
        op = 5'd21; imm_en = 1'b0; a = 32'hDEAD_BEEF; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("divu mid busy", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 64'(out_valid), 64'(0));
        chk("async reset busy", 64'(busy), 64'(0));
        chk("async reset result", 64'(result), 64'(0));
        chk("async reset flags", 64'({flag_n, flag_z, flag_c}), 64'(0));
        op = 5'd0; a = 32'd2; b = 32'd3; imm_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post reset add out_valid", 64'(out_valid), 64'(1));
        chk("post reset add result", 64'(result), 64'(5));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            seen += int'(out_valid);
        end
        chk("no stale result", 64'(seen), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
